// File: rtl/kf8255_bus_control_fifo.sv
// KF8255 bus control: samples CPU bus pins, posts completed writes to a FIFO, decodes reads. Optional macro KF8255_BUS_SYNC_EN.
// Latency: strobe rise sampled -> write_valid one edge later; bus -> read_select two edges (+2 with KF8255_BUS_SYNC_EN).
// Backpressure: write_valid/write_ready on FIFO head; a commit into a full FIFO without a pop is dropped and sets overflow_error.
module kf8255_bus_control_fifo #(
  parameter int DATA_WIDTH       = 8,
  parameter int ADDRESS_WIDTH    = 2,
  parameter int PORT_COUNT       = 4,
  parameter int WRITE_FIFO_DEPTH = 4
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              chip_select_n,
  input  logic                              read_enable_n,
  input  logic                              write_enable_n,
  input  logic [ADDRESS_WIDTH-1:0]          address,
  input  logic [DATA_WIDTH-1:0]             data_bus_in,
  output logic                              write_valid,
  input  logic                              write_ready,
  output logic [ADDRESS_WIDTH-1:0]          write_address,
  output logic [DATA_WIDTH-1:0]             write_data,
  output logic [PORT_COUNT-1:0]             write_select,
  output logic [PORT_COUNT-1:0]             read_select,
  output logic                              read_start,
  output logic [$clog2(WRITE_FIFO_DEPTH):0] fifo_level,
  output logic                              overflow_error,
  input  logic                              overflow_clear
);
  localparam int PTR_WIDTH   = $clog2(WRITE_FIFO_DEPTH);
  localparam int LEVEL_WIDTH = PTR_WIDTH + 1;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    data;
  } entry_t;

  function automatic logic [PORT_COUNT-1:0] decode(input logic [ADDRESS_WIDTH-1:0] a);
    decode = '0;
    for (int i = 0; i < PORT_COUNT; i++) decode[i] = (a == ADDRESS_WIDTH'(i));
  endfunction

  logic [2:0] strobe_in, strobe_pre;
  entry_t     bus_in, bus_pre;
  logic       smp_cs_n, smp_rd_n, smp_wr_n;
  entry_t     smp_bus;

  assign strobe_in = {chip_select_n, read_enable_n, write_enable_n};
  assign bus_in    = {address, data_bus_in};

`ifdef KF8255_BUS_SYNC_EN
  // Address/data ride a matching two-stage delay so they stay aligned with the synchronized strobes.
  logic [2:0] strobe_meta, strobe_sync;
  entry_t     bus_dly1, bus_dly2;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      strobe_meta <= '1;
      strobe_sync <= '1;
      bus_dly1    <= '0;
      bus_dly2    <= '0;
    end else begin
      strobe_meta <= strobe_in;
      strobe_sync <= strobe_meta;
      bus_dly1    <= bus_in;
      bus_dly2    <= bus_dly1;
    end
  end

  assign strobe_pre = strobe_sync;
  assign bus_pre    = bus_dly2;
`else
  assign strobe_pre = strobe_in;
  assign bus_pre    = bus_in;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      {smp_cs_n, smp_rd_n, smp_wr_n} <= 3'b111;
      smp_bus                        <= '0;
    end else begin
      {smp_cs_n, smp_rd_n, smp_wr_n} <= strobe_pre;
      smp_bus                        <= bus_pre;
    end
  end

  logic   write_active, prev_write_active, commit, push;
  entry_t hold;

  assign write_active = ~smp_wr_n & ~smp_cs_n;
  assign commit       = prev_write_active & ~write_active;
  assign push         = commit & (|decode(hold.addr));

  // Hold keeps the last sample seen while the write was active; that is what commits.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_write_active <= 1'b0;
      hold              <= '0;
    end else begin
      prev_write_active <= write_active;
      if (write_active) hold <= smp_bus;
    end
  end

  entry_t                 mem [WRITE_FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]   wr_ptr, rd_ptr;
  logic [LEVEL_WIDTH-1:0] level;
  logic                   fifo_full, pop, push_ok, overflow_set;
  entry_t                 head;

  assign write_valid  = (level != '0);
  assign fifo_full    = (level == LEVEL_WIDTH'(WRITE_FIFO_DEPTH));
  assign pop          = write_valid & write_ready;
  assign push_ok      = push & (~fifo_full | pop);
  assign overflow_set = push & fifo_full & ~pop;
  assign head         = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= hold;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level          <= '0;
      overflow_error <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      if (push_ok && !pop)      level <= level + LEVEL_WIDTH'(1);
      else if (!push_ok && pop) level <= level - LEVEL_WIDTH'(1);
      if (overflow_set)        overflow_error <= 1'b1;
      else if (overflow_clear) overflow_error <= 1'b0;
    end
  end

  // Head outputs are forced to zero when empty so stale memory never leaks out.
  assign write_address = write_valid ? head.addr : '0;
  assign write_data    = write_valid ? head.data : '0;
  assign write_select  = write_valid ? decode(head.addr) : '0;
  assign fifo_level    = level;

  logic [PORT_COUNT-1:0] read_select_next;

  always_comb begin
    read_select_next = '0;
    if (~smp_rd_n & ~smp_cs_n) read_select_next = decode(smp_bus.addr);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      read_select <= '0;
      read_start  <= 1'b0;
    end else begin
      read_select <= read_select_next;
      read_start  <= (|read_select_next) & ~(|read_select);
    end
  end

endmodule

// File: tb/tb_kf8255_bus_control_fifo.sv
// Directed bench for kf8255_bus_control_fifo: default instance plus a PORT_COUNT=3 instance on a shared bus.
module tb_kf8255_bus_control_fifo;
`ifdef KF8255_BUS_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       chip_select_n = 1'b1, read_enable_n = 1'b1, write_enable_n = 1'b1;
  logic [1:0] address = '0;
  logic [7:0] data_bus_in = '0;
  logic       write_ready = 1'b0, overflow_clear = 1'b0;

  logic       write_valid, read_start, overflow_error;
  logic [1:0] write_address;
  logic [7:0] write_data;
  logic [3:0] write_select, read_select;
  logic [2:0] fifo_level;

  logic       write_valid3, read_start3, overflow_error3;
  logic [1:0] write_address3;
  logic [7:0] write_data3;
  logic [2:0] write_select3, read_select3;
  logic [2:0] fifo_level3;

  always #5 clock = ~clock;

  kf8255_bus_control_fifo dut (
    .clock(clock), .reset_n(reset_n), .chip_select_n(chip_select_n),
    .read_enable_n(read_enable_n), .write_enable_n(write_enable_n),
    .address(address), .data_bus_in(data_bus_in), .write_valid(write_valid),
    .write_ready(write_ready), .write_address(write_address), .write_data(write_data),
    .write_select(write_select), .read_select(read_select), .read_start(read_start),
    .fifo_level(fifo_level), .overflow_error(overflow_error), .overflow_clear(overflow_clear)
  );

  kf8255_bus_control_fifo #(.PORT_COUNT(3)) dut3 (
    .clock(clock), .reset_n(reset_n), .chip_select_n(chip_select_n),
    .read_enable_n(read_enable_n), .write_enable_n(write_enable_n),
    .address(address), .data_bus_in(data_bus_in), .write_valid(write_valid3),
    .write_ready(write_ready), .write_address(write_address3), .write_data(write_data3),
    .write_select(write_select3), .read_select(read_select3), .read_start(read_start3),
    .fifo_level(fifo_level3), .overflow_error(overflow_error3), .overflow_clear(overflow_clear)
  );

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  typedef struct {
    logic [1:0] a;
    logic [7:0] d;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic expect_entry(input logic [1:0] a, input logic [7:0] d);
    exp_t e;
    e.a = a;
    e.d = d;
    sb.push_back(e);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d, input bit will_push);
    chip_select_n  = 1'b0;
    write_enable_n = 1'b0;
    address        = a;
    data_bus_in    = d;
    step(3);
    chip_select_n  = 1'b1;
    write_enable_n = 1'b1;
    if (will_push) expect_entry(a, d);
    step(2 + SYNC);
  endtask

  // Scoreboard: every accepted head must match the oldest expected write.
  always @(negedge clock) begin
    if (mon_en && write_valid && write_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_pop", 32'(write_valid), 0);
      end else begin
        mon_e = sb.pop_front();
        check("pop_addr", 32'(write_address), 32'(mon_e.a));
        check("pop_data", 32'(write_data), 32'(mon_e.d));
        check("pop_select", 32'(write_select), 32'(4'b0001 << mon_e.a));
      end
    end
  end

  initial begin
    step(2);
    check("rst_valid", 32'(write_valid), 0);
    check("rst_wsel", 32'(write_select), 0);
    check("rst_rsel", 32'(read_select), 0);
    check("rst_rstart", 32'(read_start), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_ovf", 32'(overflow_error), 0);
    check("rst_waddr", 32'(write_address), 0);
    check("rst_wdata", 32'(write_data), 0);
    check("rst_rsel3", 32'(read_select3), 0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    step(1);

    // Single write 0xA5 to address 1 with the consumer ready.
    write_ready    = 1'b1;
    chip_select_n  = 1'b0;
    write_enable_n = 1'b0;
    address        = 2'd1;
    data_bus_in    = 8'hA5;
    step(3);
    chip_select_n  = 1'b1;
    write_enable_n = 1'b1;
    expect_entry(2'd1, 8'hA5);
    step(1 + SYNC);
    check("t1_not_early", 32'(write_valid), 0);
    step(1);
    check("t1_valid", 32'(write_valid), 1);
    check("t1_addr", 32'(write_address), 1);
    check("t1_data", 32'(write_data), 'hA5);
    check("t1_wsel", 32'(write_select), 'b0010);
    check("t1_level1", 32'(fifo_level), 1);
    step(1);
    check("t1_valid_drop", 32'(write_valid), 0);
    check("t1_level0", 32'(fifo_level), 0);

    // Data changes during a long write: only the final value commits, once.
    chip_select_n  = 1'b0;
    write_enable_n = 1'b0;
    address        = 2'd0;
    data_bus_in    = 8'h11;
    step(2);
    data_bus_in    = 8'h22;
    step(2);
    chip_select_n  = 1'b1;
    write_enable_n = 1'b1;
    expect_entry(2'd0, 8'h22);
    step(2 + SYNC);
    check("t2_level1", 32'(fifo_level), 1);
    step(3);
    check("t2_single", 32'(fifo_level), 0);

    // Overflow: five writes into a depth-4 FIFO with no consumer.
    write_ready = 1'b0;
    for (int i = 1; i <= 5; i++) bus_write(2'd3, 8'(i), i <= 4);
    check("t3_level_full", 32'(fifo_level), 4);
    check("t3_ovf_set", 32'(overflow_error), 1);
    check("t3_head", 32'(write_data), 1);
    write_ready = 1'b1;
    step(8);
    check("t3_drained", 32'(fifo_level), 0);
    check("t3_ovf_sticky", 32'(overflow_error), 1);
    overflow_clear = 1'b1;
    step(1);
    overflow_clear = 1'b0;
    check("t3_ovf_clear", 32'(overflow_error), 0);
    write_ready = 1'b0;

    // Full FIFO: a commit landing on the same edge as a pop is accepted.
    for (int i = 0; i < 4; i++) bus_write(2'd2, 8'h10 + 8'(i), 1'b1);
    check("t4_level_full", 32'(fifo_level), 4);
    chip_select_n  = 1'b0;
    write_enable_n = 1'b0;
    address        = 2'd0;
    data_bus_in    = 8'h14;
    step(3);
    chip_select_n  = 1'b1;
    write_enable_n = 1'b1;
    expect_entry(2'd0, 8'h14);
    step(1 + SYNC);
    write_ready = 1'b1;
    step(1);
    write_ready = 1'b0;
    check("t4_level_same", 32'(fifo_level), 4);
    check("t4_no_ovf", 32'(overflow_error), 0);
    write_ready = 1'b1;
    step(8);
    check("t4_drained", 32'(fifo_level), 0);

    // PORT_COUNT=3 instance: out-of-range write and read decode.
    mon_en      = 1'b0;
    write_ready = 1'b0;
    reset_n     = 1'b0;
    step(1);
    reset_n     = 1'b1;
    step(1);
    bus_write(2'd3, 8'h5A, 1'b0);
    step(2);
    check("t5_oor_level3", 32'(fifo_level3), 0);
    check("t5_oor_valid3", 32'(write_valid3), 0);
    check("t5_inrange_level4", 32'(fifo_level), 1);
    chip_select_n = 1'b0;
    read_enable_n = 1'b0;
    address       = 2'd2;
    step(1 + SYNC);
    check("t5_rsel_early", 32'(read_select3), 0);
    step(1);
    check("t5_rsel_a2", 32'(read_select3), 'b100);
    check("t5_rstart", 32'(read_start3), 1);
    step(1);
    check("t5_rsel_hold", 32'(read_select3), 'b100);
    check("t5_rstart_once", 32'(read_start3), 0);
    address = 2'd1;
    step(2 + SYNC);
    check("t5_rsel_move", 32'(read_select3), 'b010);
    check("t5_rstart_move", 32'(read_start3), 0);
    chip_select_n = 1'b1;
    read_enable_n = 1'b1;
    step(2 + SYNC);
    check("t5_rsel_idle", 32'(read_select3), 0);
    chip_select_n = 1'b0;
    read_enable_n = 1'b0;
    address       = 2'd3;
    step(2 + SYNC);
    check("t5_rsel_oor", 32'(read_select3), 0);
    check("t5_rstart_oor", 32'(read_start3), 0);
    check("t5_rsel_dut4", 32'(read_select), 'b1000);
    check("t5_rstart_dut4", 32'(read_start), 1);
    chip_select_n = 1'b1;
    read_enable_n = 1'b1;
    step(2);

    // Reset in the middle of a write with two entries queued.
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    step(1);
    mon_en  = 1'b1;
    bus_write(2'd0, 8'h31, 1'b1);
    bus_write(2'd0, 8'h32, 1'b1);
    check("t6_level2", 32'(fifo_level), 2);
    chip_select_n  = 1'b0;
    write_enable_n = 1'b0;
    address        = 2'd1;
    data_bus_in    = 8'h77;
    step(2);
    #1 reset_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(write_valid), 0);
    check("t6_rst_level", 32'(fifo_level), 0);
    check("t6_rst_wsel", 32'(write_select), 0);
    check("t6_rst_wdata", 32'(write_data), 0);
    check("t6_rst_waddr", 32'(write_address), 0);
    sb.delete();
    data_bus_in = 8'h78;
    step(2);
    reset_n     = 1'b1;
    data_bus_in = 8'h79;
    step(3);
    chip_select_n  = 1'b1;
    write_enable_n = 1'b1;
    expect_entry(2'd1, 8'h79);
    step(2 + SYNC);
    check("t6_post_level", 32'(fifo_level), 1);
    check("t6_post_data", 32'(write_data), 'h79);
    write_ready = 1'b1;
    step(3);
    check("t6_final_level", 32'(fifo_level), 0);
    check("sb_drained", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
